// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-level valid/ready handshake into the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serializer with a one-entry holding register, 5-8 data
//               bits LSB first, optional parity and one or two stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx (
    input  wire         clk_i,
    input  wire         rst_i,
    input  wire         cfg_en_i,
    input  wire  [15:0] cfg_div_i,
    input  wire         cfg_parity_en_i,
    input  wire  [1:0]  cfg_parity_sel_i,
    input  wire  [1:0]  cfg_bits_i,
    input  wire         cfg_stop_bits_i,
    uart_tx_if.slave    tx_if,
    output logic        tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_hold_valid;
    logic [7:0]  r_hold_data;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_nxt;
    logic        r_xor;
    logic        w_xor_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic [1:0]  r_bits;
    logic        r_par_en;
    logic [1:0]  r_par_sel;
    logic        r_stop2;

    logic        w_bit_done;
    logic        w_last_data;
    logic        w_final_stop;
    logic        w_load;
    logic        w_accept;

    // >= rather than == so a live divider shrink cannot strand the counter
    assign w_bit_done   = (r_state != S_IDLE) && (r_baud >= cfg_div_i);
    assign w_last_data  = (r_bit_cnt == {1'b1, r_bits});
    assign w_final_stop = (r_state == S_STOP) && w_bit_done && (!r_stop2 || r_bit_cnt[0]);
    assign w_load       = r_hold_valid && ((r_state == S_IDLE) || w_final_stop);

    assign tx_if.tx_ready = cfg_en_i && !r_hold_valid && !rst_i;
    assign w_accept       = tx_if.tx_valid && tx_if.tx_ready;

    assign tx_o   = r_tx;
    assign busy_o = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_xor_nxt     = r_xor;
        w_tx_nxt      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = r_hold_data;
                    w_xor_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_xor_nxt   = r_xor ^ r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (w_last_data) begin
                        w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt   = S_STOP;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    if (w_final_stop) begin
                        if (w_load) begin
                            w_state_nxt = S_START;
                            w_shift_nxt = r_hold_data;
                            w_xor_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_cnt_nxt = 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level for the state being entered, so tx_o stays a flop output
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: begin
                case (r_par_sel)
                    2'b00:   w_tx_nxt = ~w_xor_nxt;
                    2'b01:   w_tx_nxt = w_xor_nxt;
                    2'b10:   w_tx_nxt = 1'b0;
                    default: w_tx_nxt = 1'b1;
                endcase
            end
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            r_state      <= S_IDLE;
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'd0;
            r_shift      <= 8'd0;
            r_baud       <= 16'd0;
            r_bit_cnt    <= 3'd0;
            r_xor        <= 1'b0;
            r_tx         <= 1'b1;
            r_bits       <= 2'd0;
            r_par_en     <= 1'b0;
            r_par_sel    <= 2'd0;
            r_stop2      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_xor     <= w_xor_nxt;
            r_tx      <= w_tx_nxt;

            if (w_bit_done || (r_state == S_IDLE)) begin
                r_baud <= 16'd0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end

            if (w_load) begin
                r_hold_valid <= 1'b0;
                r_bits       <= cfg_bits_i;
                r_par_en     <= cfg_parity_en_i;
                r_par_sel    <= cfg_parity_sel_i;
                r_stop2      <= cfg_stop_bits_i;
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= tx_if.tx_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        cfg_parity_en;
    logic [1:0]  cfg_parity_sel;
    logic [1:0]  cfg_bits;
    logic        cfg_stop_bits;
    logic        tx;
    logic        busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    uart_tx_if tx_if();

    uart_tx dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_en_i         (cfg_en),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_sel_i (cfg_parity_sel),
        .cfg_bits_i       (cfg_bits),
        .cfg_stop_bits_i  (cfg_stop_bits),
        .tx_if            (tx_if.slave),
        .tx_o             (tx),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for a single edge; returns in the cycle after the handshake
    task automatic send(input logic [7:0] d);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        cyc();
        tx_if.tx_valid = 1'b0;
    endtask

    // pat bit 0 is the first bit on the line; starts in the first start-bit cycle
    task automatic check_frame(input string tag, input logic [31:0] pat,
                               input int nbits, input int per, input int drop_at);
        int idx;
        idx = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < per; c++) begin
                if (idx == drop_at) tx_if.tx_valid = 1'b0;
                check($sformatf("%s tx bit%0d cyc%0d", tag, b, c), {15'd0, tx}, {15'd0, pat[b]});
                check($sformatf("%s busy bit%0d cyc%0d", tag, b, c), {15'd0, busy}, 16'd1);
                idx++;
                cyc();
            end
        end
        check($sformatf("%s busy after", tag), {15'd0, busy}, 16'd0);
        check($sformatf("%s tx after", tag), {15'd0, tx}, 16'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        cfg_en         = 1'b1;
        cfg_div        = 16'd3;
        cfg_parity_en  = 1'b0;
        cfg_parity_sel = 2'b00;
        cfg_bits       = 2'b11;
        cfg_stop_bits  = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        cyc();
        cyc();
        check("reset tx", {15'd0, tx}, 16'd1);
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset ready", {15'd0, tx_if.tx_ready}, 16'd0);
        rst = 1'b0;
        cyc();
        check("post-reset ready", {15'd0, tx_if.tx_ready}, 16'd1);

        // 8N1, div=3, 0x55
        send(8'h55);
        check("t1 ready C+1", {15'd0, tx_if.tx_ready}, 16'd0);
        check("t1 tx C+1", {15'd0, tx}, 16'd1);
        check("t1 busy C+1", {15'd0, busy}, 16'd0);
        cyc();
        check("t1 ready C+2", {15'd0, tx_if.tx_ready}, 16'd1);
        check_frame("t1", {1'b1, 8'h55, 1'b0}, 10, 4, -1);

        // 8O1, div=1
        cfg_div       = 16'd1;
        cfg_parity_en = 1'b1;
        cfg_parity_sel = 2'b00;
        cyc();
        send(8'h03);
        cyc();
        check_frame("t2a", {1'b1, 1'b1, 8'h03, 1'b0}, 11, 2, -1);
        send(8'h07);
        cyc();
        check_frame("t2b", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, -1);

        // 5 bits, mark parity, two stops, div=0
        cfg_div        = 16'd0;
        cfg_bits       = 2'b00;
        cfg_parity_sel = 2'b11;
        cfg_stop_bits  = 1'b1;
        cyc();
        send(8'hFF);
        cyc();
        check_frame("t3a", {2'b11, 1'b1, 5'h1F, 1'b0}, 9, 1, -1);

        // 6 bits, even parity, one stop: upper bits of 0xED must not appear
        cfg_bits       = 2'b01;
        cfg_parity_sel = 2'b01;
        cfg_stop_bits  = 1'b0;
        cyc();
        send(8'hED);
        cyc();
        check_frame("t3b", {1'b1, 1'b0, 6'h2D, 1'b0}, 9, 1, -1);

        // Back-to-back 8N1, div=2
        cfg_div       = 16'd2;
        cfg_bits      = 2'b11;
        cfg_parity_en = 1'b0;
        cyc();
        tx_if.tx_data  = 8'hA5;
        tx_if.tx_valid = 1'b1;
        cyc();
        check("t4 ready C+1", {15'd0, tx_if.tx_ready}, 16'd0);
        cyc();
        check("t4 ready C+2", {15'd0, tx_if.tx_ready}, 16'd1);
        tx_if.tx_data = 8'h3C;
        check_frame("t4", {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, 3, 1);

        // Enable dropped mid data bit 3 with a byte pending
        cfg_div = 16'd3;
        cyc();
        send(8'hF7);
        cyc();
        tx_if.tx_data = 8'h11;
        tx_if.tx_valid = 1'b1;
        cyc();
        tx_if.tx_valid = 1'b0;
        for (int i = 0; i < 16; i++) cyc();
        check("t5 tx bit3", {15'd0, tx}, 16'd0);
        check("t5 busy bit3", {15'd0, busy}, 16'd1);
        check("t5 ready pending", {15'd0, tx_if.tx_ready}, 16'd0);
        cfg_en = 1'b0;
        cyc();
        check("t5 tx disabled", {15'd0, tx}, 16'd1);
        check("t5 busy disabled", {15'd0, busy}, 16'd0);
        check("t5 ready disabled", {15'd0, tx_if.tx_ready}, 16'd0);
        cyc();
        cfg_en = 1'b1;
        cyc();
        check("t5 ready re-enabled", {15'd0, tx_if.tx_ready}, 16'd1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t5 idle tx %0d", i), {15'd0, tx}, 16'd1);
            check($sformatf("t5 idle busy %0d", i), {15'd0, busy}, 16'd0);
            cyc();
        end

        // Reset during the parity bit with a byte pending
        cfg_parity_en  = 1'b1;
        cfg_parity_sel = 2'b01;
        send(8'h03);
        cyc();
        tx_if.tx_data  = 8'h22;
        tx_if.tx_valid = 1'b1;
        cyc();
        tx_if.tx_valid = 1'b0;
        for (int i = 0; i < 36; i++) cyc();
        check("t6 tx parity", {15'd0, tx}, 16'd0);
        check("t6 busy parity", {15'd0, busy}, 16'd1);
        check("t6 ready pending", {15'd0, tx_if.tx_ready}, 16'd0);
        rst = 1'b1;
        cyc();
        check("t6 tx reset", {15'd0, tx}, 16'd1);
        check("t6 busy reset", {15'd0, busy}, 16'd0);
        check("t6 ready reset", {15'd0, tx_if.tx_ready}, 16'd0);
        rst = 1'b0;
        #1;
        check("t6 ready released", {15'd0, tx_if.tx_ready}, 16'd1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check($sformatf("t6 idle tx %0d", i), {15'd0, tx}, 16'd1);
            check($sformatf("t6 idle busy %0d", i), {15'd0, busy}, 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
